// File: rtl/mig_addr_drain.sv
// mig_addr_drain: queries the hot-address CAM, snapshots its contents during
// the one-cycle query-ready window, and streams the non-empty entries out in
// descending index order to the page-migration engine.
module mig_addr_drain #(
  parameter int NUM_ENTRY  = 25,
  parameter int INDEX_SIZE = 5,
  parameter int ADDR_SIZE  = 22,
  parameter int PERIOD_W   = 32,
  parameter int TIMEOUT    = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                cfg_enable,
  input  logic [PERIOD_W-1:0]                 cfg_period,
  input  logic                                sw_trigger,
  output logic                                query_en,
  input  logic                                query_ready,
  input  logic [NUM_ENTRY-1:0][ADDR_SIZE-1:0] snap_addr,
  output logic                                mig_valid,
  output logic [ADDR_SIZE-1:0]                mig_addr,
  output logic [INDEX_SIZE-1:0]               mig_index,
  output logic                                mig_last,
  input  logic                                mig_ready,
  output logic                                busy,
  output logic [15:0]                         stat_queries,
  output logic [15:0]                         stat_sent,
  output logic [7:0]                          stat_timeouts
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0]                          state_q, state_d;
  logic                                pending_q, pending_d;
  logic [PERIOD_W-1:0]                 timer_q, timer_d;
  logic [TO_W-1:0]                     wait_cnt_q, wait_cnt_d;
  logic [INDEX_SIZE-1:0]               ptr_q, ptr_d;
  logic [NUM_ENTRY-1:0][ADDR_SIZE-1:0] snap_q, snap_d;
  logic [NUM_ENTRY-1:0]                mask_q, mask_d;
  logic [15:0]                         queries_q, queries_d;
  logic [15:0]                         sent_q, sent_d;
  logic [7:0]                          timeouts_q, timeouts_d;

  logic                                timer_en;
  logic                                timer_hit;
  logic [NUM_ENTRY-1:0]                cap_mask;
  logic                                lower_any;

  // Period timer: free-runs while enabled, wraps at cfg_period-1 and raises a request.
  always_comb begin
    timer_en  = cfg_enable && (cfg_period != '0);
    timer_hit = timer_en && (timer_q >= (cfg_period - PERIOD_W'(1)));
    if (!timer_en || timer_hit) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + PERIOD_W'(1);
    end
  end

  // Occupancy mask of the live CAM snapshot, and whether any valid entry sits below ptr.
  always_comb begin
    cap_mask  = '0;
    lower_any = 1'b0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      cap_mask[i] = (snap_addr[i] != '0);
      if (INDEX_SIZE'(i) < ptr_q) begin
        lower_any = lower_any | mask_q[i];
      end
    end
  end

  // Stream outputs come straight from the private snapshot at the current pointer.
  always_comb begin
    query_en      = (state_q == ST_ISSUE);
    busy          = (state_q != ST_IDLE);
    mig_valid     = (state_q == ST_DRAIN) && mask_q[ptr_q];
    mig_addr      = mig_valid ? snap_q[ptr_q] : '0;
    mig_index     = mig_valid ? ptr_q : '0;
    mig_last      = mig_valid && !lower_any;
    stat_queries  = queries_q;
    stat_sent     = sent_q;
    stat_timeouts = timeouts_q;
  end

  // Query sequencing, snapshot capture and descending drain walk.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q | sw_trigger | timer_hit;
    wait_cnt_d = wait_cnt_q;
    ptr_d      = ptr_q;
    snap_d     = snap_q;
    mask_d     = mask_q;
    queries_d  = queries_q;
    sent_d     = sent_q;
    timeouts_d = timeouts_q;
    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          state_d   = ST_ISSUE;
          pending_d = sw_trigger | timer_hit;
        end
      end
      ST_ISSUE: begin
        state_d    = ST_WAIT;
        wait_cnt_d = '0;
      end
      ST_WAIT: begin
        if (query_ready) begin
          snap_d    = snap_addr;
          mask_d    = cap_mask;
          ptr_d     = INDEX_SIZE'(NUM_ENTRY - 1);
          queries_d = queries_q + 16'd1;
          state_d   = (cap_mask != '0) ? ST_DRAIN : ST_IDLE;
        end else if (wait_cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          if (timeouts_q != 8'hFF) begin
            timeouts_d = timeouts_q + 8'd1;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + TO_W'(1);
        end
      end
      ST_DRAIN: begin
        if (!mask_q[ptr_q]) begin
          if (ptr_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            ptr_d = ptr_q - INDEX_SIZE'(1);
          end
        end else if (mig_ready) begin
          sent_d = sent_q + 16'd1;
          if (mig_last) begin
            state_d = ST_IDLE;
          end else begin
            ptr_d = ptr_q - INDEX_SIZE'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pending_q  <= 1'b0;
      timer_q    <= '0;
      wait_cnt_q <= '0;
      ptr_q      <= '0;
      snap_q     <= '0;
      mask_q     <= '0;
      queries_q  <= '0;
      sent_q     <= '0;
      timeouts_q <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      timer_q    <= timer_d;
      wait_cnt_q <= wait_cnt_d;
      ptr_q      <= ptr_d;
      snap_q     <= snap_d;
      mask_q     <= mask_d;
      queries_q  <= queries_d;
      sent_q     <= sent_d;
      timeouts_q <= timeouts_d;
    end
  end

endmodule

// File: tb/tb_mig_addr_drain.sv
// tb_mig_addr_drain: drives mig_addr_drain with a behavioural CAM and a
// randomised migration engine, comparing the stream, timing and statistics
// against a queue-based reference model of the drain.
module tb_mig_addr_drain;

  localparam int NUM_ENTRY  = 25;
  localparam int INDEX_SIZE = 5;
  localparam int ADDR_SIZE  = 22;
  localparam int PERIOD_W   = 32;
  localparam int TIMEOUT    = 8;

  logic                                clk = 1'b0;
  logic                                rst_n;
  logic                                cfg_enable;
  logic [PERIOD_W-1:0]                 cfg_period;
  logic                                sw_trigger;
  logic                                query_en;
  logic                                query_ready;
  logic [NUM_ENTRY-1:0][ADDR_SIZE-1:0] snap_addr;
  logic                                mig_valid;
  logic [ADDR_SIZE-1:0]                mig_addr;
  logic [INDEX_SIZE-1:0]               mig_index;
  logic                                mig_last;
  logic                                mig_ready;
  logic                                busy;
  logic [15:0]                         stat_queries;
  logic [15:0]                         stat_sent;
  logic [7:0]                          stat_timeouts;

  mig_addr_drain #(
    .NUM_ENTRY (NUM_ENTRY),
    .INDEX_SIZE(INDEX_SIZE),
    .ADDR_SIZE (ADDR_SIZE),
    .PERIOD_W  (PERIOD_W),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_enable   (cfg_enable),
    .cfg_period   (cfg_period),
    .sw_trigger   (sw_trigger),
    .query_en     (query_en),
    .query_ready  (query_ready),
    .snap_addr    (snap_addr),
    .mig_valid    (mig_valid),
    .mig_addr     (mig_addr),
    .mig_index    (mig_index),
    .mig_last     (mig_last),
    .mig_ready    (mig_ready),
    .busy         (busy),
    .stat_queries (stat_queries),
    .stat_sent    (stat_sent),
    .stat_timeouts(stat_timeouts)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int modelQueries = 0;
  int modelSent = 0;
  int modelTimeouts = 0;

  logic [ADDR_SIZE-1:0] camSnap [NUM_ENTRY];
  int camDelay = -1;
  int camArm = 0;
  bit strayReady = 1'b0;
  bit prevQe = 1'b0;
  int qeCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkStats();
    checkOutput("stat_queries", 32'(stat_queries), 32'(modelQueries & 16'hFFFF));
    checkOutput("stat_sent", 32'(stat_sent), 32'(modelSent & 16'hFFFF));
    checkOutput("stat_timeouts", 32'(stat_timeouts), 32'(modelTimeouts));
  endtask

  // One clock: move to the falling edge, then play the CAM side of the link.
  task automatic advanceCycle();
    bit fire;
    @(negedge clk);
    sw_trigger = 1'b0;
    fire = 1'b0;
    if (camArm > 0) begin
      camArm--;
      fire = (camArm == 0);
    end
    query_ready = fire || strayReady;
    strayReady = 1'b0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      snap_addr[i] = fire ? camSnap[i] : ADDR_SIZE'($urandom);
    end
    if (query_en === 1'b1) begin
      qeCount++;
      checkOutput("qe_width", 32'(prevQe), 32'd0);
      if (camDelay >= 0) camArm = camDelay + 1;
    end
    prevQe = (query_en === 1'b1);
  endtask

  // One software-triggered query; d<0 means the CAM never answers.
  // readyMode: 0 always ready, 1 random, 2 first beat stalled for 5 cycles.
  task automatic applyStimulus(input int d, input int readyMode, input bit midTrig);
    int c;
    int expIdx[$];
    logic [ADDR_SIZE-1:0] expAddr[$];
    int stalls;
    int holdLeft;
    bit prevStall;
    bit done;
    bit r;
    camDelay = d;
    for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
      if (camSnap[i] != '0) begin
        expIdx.push_back(i);
        expAddr.push_back(camSnap[i]);
      end
    end
    mig_ready = 1'b0;
    sw_trigger = 1'b1;
    c = 0;
    advanceCycle(); c++;
    checkOutput("trig_pending", 32'(query_en), 32'd0);
    advanceCycle(); c++;
    checkOutput("trig_issue", 32'(query_en), 32'd1);
    if (d < 0) begin
      while (c < 2 + TIMEOUT) begin advanceCycle(); c++; end
      checkOutput("wait_busy", 32'(busy), 32'd1);
      advanceCycle(); c++;
      checkOutput("timeout_idle", 32'(busy), 32'd0);
      if (modelTimeouts < 255) modelTimeouts++;
    end else if (expIdx.size() == 0) begin
      while (c < 3 + d) begin advanceCycle(); c++; end
      checkOutput("empty_wait", 32'(busy), 32'd1);
      advanceCycle(); c++;
      checkOutput("empty_idle", 32'(busy), 32'd0);
      checkOutput("empty_valid", 32'(mig_valid), 32'd0);
      modelQueries++;
    end else begin
      modelQueries++;
      stalls = 0;
      holdLeft = (readyMode == 2) ? 5 : 0;
      prevStall = 1'b0;
      done = 1'b0;
      while (!done && c < 600) begin
        advanceCycle(); c++;
        if (midTrig && (c == 5 + d || c == 7 + d)) sw_trigger = 1'b1;
        if (prevStall) checkOutput("hold_valid", 32'(mig_valid), 32'd1);
        if (mig_valid === 1'b1) begin
          checkOutput("beat_index", 32'(mig_index), 32'(expIdx[0]));
          checkOutput("beat_addr", 32'(mig_addr), 32'(expAddr[0]));
          checkOutput("beat_last", 32'(mig_last), 32'(expIdx.size() == 1));
          checkOutput("beat_cycle", 32'(c), 32'(4 + d + (NUM_ENTRY - 1 - expIdx[0]) + stalls));
          if (readyMode == 0) begin
            r = 1'b1;
          end else if (readyMode == 1) begin
            r = 1'($urandom_range(0, 1));
          end else begin
            r = (holdLeft == 0);
            if (holdLeft > 0) holdLeft--;
          end
          mig_ready = r;
          if (r) begin
            void'(expIdx.pop_front());
            void'(expAddr.pop_front());
            modelSent++;
            prevStall = 1'b0;
            if (expIdx.size() == 0) done = 1'b1;
          end else begin
            stalls++;
            prevStall = 1'b1;
          end
        end else begin
          checkOutput("idle_last", 32'(mig_last), 32'd0);
          mig_ready = 1'($urandom_range(0, 1));
          prevStall = 1'b0;
        end
      end
      if (!done) checkOutput("drain_budget", 32'(expIdx.size()), 32'd0);
      advanceCycle(); c++;
      mig_ready = 1'b0;
      checkOutput("drain_end_busy", 32'(busy), 32'd0);
      checkOutput("drain_end_valid", 32'(mig_valid), 32'd0);
    end
    checkStats();
  endtask

  initial begin
    int qeTimes[$];
    int qeBefore;
    rst_n = 1'b0;
    cfg_enable = 1'b0;
    cfg_period = '0;
    sw_trigger = 1'b0;
    query_ready = 1'b0;
    mig_ready = 1'b0;
    snap_addr = '0;
    for (int i = 0; i < NUM_ENTRY; i++) camSnap[i] = '0;

    // Reset state
    repeat (3) advanceCycle();
    checkOutput("rst_query_en", 32'(query_en), 32'd0);
    checkOutput("rst_valid", 32'(mig_valid), 32'd0);
    checkOutput("rst_addr", 32'(mig_addr), 32'd0);
    checkOutput("rst_index", 32'(mig_index), 32'd0);
    checkOutput("rst_last", 32'(mig_last), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkStats();
    rst_n = 1'b1;
    advanceCycle();

    // Full snapshot, addr = index+1, ready tied high
    for (int i = 0; i < NUM_ENTRY; i++) camSnap[i] = ADDR_SIZE'(i + 1);
    applyStimulus(0, 0, 1'b0);
    checkOutput("full_sent", 32'(stat_sent), 32'd25);
    checkOutput("full_queries", 32'(stat_queries), 32'd1);

    // Sparse snapshot: 20, 7, 3
    for (int i = 0; i < NUM_ENTRY; i++) camSnap[i] = '0;
    camSnap[20] = ADDR_SIZE'($urandom) | ADDR_SIZE'(1);
    camSnap[7]  = ADDR_SIZE'($urandom) | ADDR_SIZE'(1);
    camSnap[3]  = ADDR_SIZE'($urandom) | ADDR_SIZE'(1);
    applyStimulus(2, 0, 1'b0);

    // Empty snapshot
    for (int i = 0; i < NUM_ENTRY; i++) camSnap[i] = '0;
    applyStimulus(1, 0, 1'b0);

    // Backpressure on the first beat
    for (int i = 0; i < NUM_ENTRY; i++) camSnap[i] = ($urandom_range(0, 1) == 1) ? ADDR_SIZE'($urandom) : '0;
    camSnap[NUM_ENTRY - 1] = ADDR_SIZE'($urandom) | ADDR_SIZE'(1);
    applyStimulus(0, 2, 1'b0);

    // Random snapshots, random CAM latency, random ready
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < NUM_ENTRY; i++) camSnap[i] = ($urandom_range(0, 2) == 0) ? ADDR_SIZE'($urandom) : '0;
      applyStimulus(int'($urandom_range(0, TIMEOUT - 1)), 1, 1'b0);
    end

    // A query_ready outside WAIT is ignored
    strayReady = 1'b1;
    repeat (3) advanceCycle();
    checkOutput("stray_busy", 32'(busy), 32'd0);
    checkOutput("stray_valid", 32'(mig_valid), 32'd0);
    checkStats();

    // Triggers during DRAIN coalesce into exactly one extra query
    for (int i = 0; i < NUM_ENTRY; i++) camSnap[i] = ADDR_SIZE'($urandom) | ADDR_SIZE'(1);
    applyStimulus(0, 1, 1'b1);
    for (int i = 0; i < NUM_ENTRY; i++) camSnap[i] = '0;
    qeBefore = qeCount;
    repeat (40) advanceCycle();
    checkOutput("midtrig_extra", 32'(qeCount - qeBefore), 32'd1);
    modelQueries++;
    checkStats();

    // Period timer
    camDelay = 0;
    cfg_period = 32'd100;
    cfg_enable = 1'b1;
    for (int k = 1; k <= 450; k++) begin
      advanceCycle();
      if (query_en === 1'b1) qeTimes.push_back(k);
    end
    cfg_enable = 1'b0;
    repeat (10) advanceCycle();
    checkOutput("timer_count", 32'(qeTimes.size()), 32'd4);
    if (qeTimes.size() > 0) checkOutput("timer_first", 32'(qeTimes[0]), 32'd101);
    for (int i = 1; i < qeTimes.size(); i++) checkOutput("timer_interval", 32'(qeTimes[i] - qeTimes[i - 1]), 32'd100);
    modelQueries += 4;
    checkStats();

    // Period 0 disables the timer
    cfg_period = '0;
    cfg_enable = 1'b1;
    qeBefore = qeCount;
    repeat (250) advanceCycle();
    checkOutput("timer_off", 32'(qeCount - qeBefore), 32'd0);
    cfg_enable = 1'b0;

    // Timeouts and saturation
    applyStimulus(-1, 0, 1'b0);
    checkOutput("timeout_one", 32'(stat_timeouts), 32'd1);
    for (int n = 0; n < 299; n++) applyStimulus(-1, 0, 1'b0);
    checkOutput("timeout_sat", 32'(stat_timeouts), 32'd255);

    // Reset in the middle of a drain
    for (int i = 0; i < NUM_ENTRY; i++) camSnap[i] = ADDR_SIZE'(i + 1);
    camDelay = 0;
    mig_ready = 1'b0;
    sw_trigger = 1'b1;
    for (int k = 0; k < 30 && mig_valid !== 1'b1; k++) advanceCycle();
    checkOutput("pre_reset_valid", 32'(mig_valid), 32'd1);
    rst_n = 1'b0;
    advanceCycle();
    checkOutput("reset_drop_valid", 32'(mig_valid), 32'd0);
    checkOutput("reset_drop_busy", 32'(busy), 32'd0);
    modelQueries = 0;
    modelSent = 0;
    modelTimeouts = 0;
    checkStats();
    rst_n = 1'b1;
    advanceCycle();

    // Operation resumes cleanly after reset
    for (int i = 0; i < NUM_ENTRY; i++) camSnap[i] = '0;
    camSnap[0] = ADDR_SIZE'($urandom) | ADDR_SIZE'(1);
    camSnap[12] = ADDR_SIZE'($urandom) | ADDR_SIZE'(1);
    applyStimulus(3, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
